nes_pad_emulator: RTL and testbench

Device-side emulation of an NES game pad's parallel-in/serial-out shift register. It is the responder to the `nes_controller` host that drives `latch` and `c_clk` and samples `data`. It lets a second board, or a test harness built around the FPGA fabric, present eight button states to the Pong host over the standard three-wire pad interface. It also reports poll activity and host presence for debug LEDs.

---
 rtl/nes_pad_emulator.sv | 147 ++++++++++++++
 tb/tb_nes_pad_emulator.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_pad_emulator.sv
// NES pad emulator: answers a host's latch/c_clk with eight buttons shifted out as active-low serial data.
// Also reports completed polls (strobe and wrapping count) and whether a host has polled recently.
module nes_pad_emulator #(
  parameter int FILTER_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  buttons,
  input  logic        latch,
  input  logic        c_clk,
  output logic        data,
  output logic        poll_strobe,
  output logic        host_active,
  output logic [15:0] poll_count
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    F_MAX = 4'(FILTER_CYCLES);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic           latch_s1_q, latch_s2_q;
  logic           cclk_s1_q, cclk_s2_q, cclk_dly_q, cclk_rise_q, cclk_rise_d;
  logic [3:0]     filt_q, filt_d;
  logic [7:0]     sr_q, sr_d;
  logic [3:0]     idx_q, idx_d;
  logic           data_q, data_d;
  logic           strobe_q, strobe_d;
  logic           active_q, active_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [15:0]    count_q, count_d;

  logic latch_ok, timeout, enter_load, shift_ev, last_bit;

  always_comb begin
    latch_ok    = (filt_q == F_MAX);
    timeout     = (timer_q == T_MAX);
    enter_load  = latch_ok && (state_q != LOAD);
    // A shift edge coinciding with a held latch loses to the load.
    shift_ev    = cclk_rise_q && !latch_s2_q;
    last_bit    = (state_q == SHIFT) && shift_ev && (idx_q == 4'd7);
    cclk_rise_d = cclk_s2_q && !cclk_dly_q;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (latch_ok) state_d = LOAD;
      LOAD:    if (!latch_s2_q) state_d = SHIFT;
      SHIFT:   if (latch_ok) state_d = LOAD;
               else if (last_bit) state_d = DONE;
      DONE:    if (latch_ok) state_d = LOAD;
      default: state_d = IDLE;
    endcase
    if (timeout && !enter_load) state_d = IDLE;
  end

  // Datapath next values
  always_comb begin
    filt_d = 4'd0;
    if (latch_s2_q) filt_d = latch_ok ? filt_q : filt_q + 4'd1;

    sr_d  = sr_q;
    idx_d = idx_q;
    if (state_d == LOAD) begin
      sr_d  = ~buttons;
      idx_d = 4'd0;
    end else if ((state_q == SHIFT) && shift_ev && (state_d != IDLE)) begin
      sr_d  = {1'b0, sr_q[7:1]};
      idx_d = idx_q + 4'd1;
    end

    strobe_d = last_bit && (state_d == DONE);
    count_d  = count_q + {15'd0, strobe_d};

    timer_d  = timer_q;
    active_d = active_q;
    if (enter_load) begin
      timer_d  = '0;
      active_d = 1'b1;
    end else if (timeout) begin
      active_d = 1'b0;
    end else begin
      timer_d  = timer_q + TW'(1);
    end
  end

  // FSM: output
  always_comb begin
    data_d = sr_d[0];
    case (state_d)
      IDLE:    data_d = 1'b1;
      DONE:    data_d = 1'b0;
      default: data_d = sr_d[0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch_s1_q  <= 1'b0;
      latch_s2_q  <= 1'b0;
      cclk_s1_q   <= 1'b0;
      cclk_s2_q   <= 1'b0;
      cclk_dly_q  <= 1'b0;
      cclk_rise_q <= 1'b0;
      filt_q      <= 4'd0;
      sr_q        <= 8'hFF;
      idx_q       <= 4'd0;
      data_q      <= 1'b1;
      strobe_q    <= 1'b0;
      active_q    <= 1'b0;
      timer_q     <= '0;
      count_q     <= 16'd0;
    end else begin
      latch_s1_q  <= latch;
      latch_s2_q  <= latch_s1_q;
      cclk_s1_q   <= c_clk;
      cclk_s2_q   <= cclk_s1_q;
      cclk_dly_q  <= cclk_s2_q;
      cclk_rise_q <= cclk_rise_d;
      filt_q      <= filt_d;
      sr_q        <= sr_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      strobe_q    <= strobe_d;
      active_q    <= active_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
    end
  end

  assign data        = data_q;
  assign poll_strobe = strobe_q;
  assign host_active = active_q;
  assign poll_count  = count_q;

endmodule

// File: tb/tb_nes_pad_emulator.sv
// Bench for nes_pad_emulator: random button patterns polled over latch/c_clk, compared to a pad model.
module tb_nes_pad_emulator;
  localparam int FC = 2;
  localparam int TC = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  buttons = 8'h00;
  logic        latch = 1'b0;
  logic        c_clk = 1'b0;
  logic        data, poll_strobe, host_active;
  logic [15:0] poll_count;

  int total = 0;
  int bad = 0;
  int strobes = 0;
  int cyc = 0;
  int t_latch = 0;
  int exp_polls = 0;

  nes_pad_emulator #(.FILTER_CYCLES(FC), .TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .reset(reset), .buttons(buttons), .latch(latch), .c_clk(c_clk),
    .data(data), .poll_strobe(poll_strobe), .host_active(host_active), .poll_count(poll_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1;
    if (poll_strobe === 1'b1) strobes = strobes + 1;
  end

  // Reference pad: bit k of a poll is the inverted button, zeros after the eighth.
  function automatic logic model_bit(input logic [7:0] b, input int k);
    logic [7:0] inv;
    inv = ~b;
    return (k < 8) ? inv[k] : 1'b0;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_latch(input int hi);
    t_latch = cyc;
    latch = 1'b1;
    idle(hi);
    latch = 1'b0;
    idle(4);
  endtask

  task automatic pulse(input int hi, input int lo);
    c_clk = 1'b1;
    idle(hi);
    c_clk = 1'b0;
    idle(lo);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    exp_polls = 0;
    idle(1);
  endtask

  // Shifts bits first..7 out and checks each against the model for pattern b.
  task automatic shift_rest(input logic [7:0] b, input int first, input int hi, input int lo, input string tag);
    for (int k = first; k < 8; k++) begin
      pulse(hi, lo);
      total++;
      if (data !== model_bit(b, k + 1)) begin
        bad++;
        $display("FAIL %s bit%0d: got %b want %b", tag, k + 1, data, model_bit(b, k + 1));
      end
    end
  endtask

  task automatic run_poll(input logic [7:0] b, input int hi, input int lo, input string tag);
    int s0;
    s0 = strobes;
    buttons = b;
    do_latch(12);
    total++;
    if (data !== model_bit(b, 0)) begin
      bad++;
      $display("FAIL %s bit0: got %b want %b", tag, data, model_bit(b, 0));
    end
    shift_rest(b, 0, hi, lo, tag);
    exp_polls++;
    total++;
    if (strobes - s0 !== 1) begin
      bad++;
      $display("FAIL %s strobes: got %0d want 1", tag, strobes - s0);
    end
  endtask

  task automatic test_reset();
    idle(2);
    total += 4;
    if (data !== 1'b1)        begin bad++; $display("FAIL reset data: got %b want 1", data); end
    if (poll_strobe !== 1'b0) begin bad++; $display("FAIL reset strobe: got %b want 0", poll_strobe); end
    if (host_active !== 1'b0) begin bad++; $display("FAIL reset active: got %b want 0", host_active); end
    if (poll_count !== 16'd0) begin bad++; $display("FAIL reset count: got %0d want 0", poll_count); end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_basic_poll();
    run_poll(8'b1000_0101, 6, 6, "basic");
    total += 2;
    if (poll_count !== 16'(exp_polls)) begin bad++; $display("FAIL basic count: got %0d want %0d", poll_count, exp_polls); end
    if (host_active !== 1'b1) begin bad++; $display("FAIL basic active: got %b want 1", host_active); end
  endtask

  task automatic test_random_polls();
    for (int n = 0; n < 5; n++) begin
      run_poll(8'($urandom), $urandom_range(3, 7), $urandom_range(3, 7), "random");
      total++;
      if (poll_count !== 16'(exp_polls)) begin bad++; $display("FAIL random count: got %0d want %0d", poll_count, exp_polls); end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] b;
    apply_reset();
    b = 8'($urandom) | 8'h01;
    buttons = b;
    latch = 1'b1;
    idle(1);
    latch = 1'b0;
    idle(8);
    total += 2;
    if (data !== 1'b1)        begin bad++; $display("FAIL glitch data: got %b want 1", data); end
    if (host_active !== 1'b0) begin bad++; $display("FAIL glitch active: got %b want 0", host_active); end
    do_latch(6);
    total += 2;
    if (data !== model_bit(b, 0)) begin bad++; $display("FAIL glitch6 data: got %b want %b", data, model_bit(b, 0)); end
    if (host_active !== 1'b1) begin bad++; $display("FAIL glitch6 active: got %b want 1", host_active); end
  endtask

  task automatic test_abort();
    logic [7:0] b;
    int s0;
    int c0;
    b = 8'($urandom);
    buttons = b;
    do_latch(12);
    shift_rest(b, 0, 6, 6, "abort_pre");
    // Re-run just three of the shifts before aborting, on a fresh poll.
    buttons = b;
    do_latch(12);
    for (int k = 0; k < 3; k++) pulse(6, 6);
    s0 = strobes;
    c0 = int'(poll_count);
    b = 8'($urandom) | 8'h01;
    buttons = b;
    latch = 1'b1;
    idle(FC + 4);
    total += 1;
    if (data !== 1'b0) begin bad++; $display("FAIL abort data: got %b want 0", data); end
    latch = 1'b0;
    idle(4);
    total += 2;
    if (strobes !== s0) begin bad++; $display("FAIL abort strobes: got %0d want %0d", strobes, s0); end
    if (int'(poll_count) !== c0) begin bad++; $display("FAIL abort count: got %0d want %0d", poll_count, c0); end
    shift_rest(b, 0, 6, 6, "abort_post");
    total++;
    if (int'(poll_count) !== ((c0 + 1) % 65536)) begin bad++; $display("FAIL abort count+1: got %0d want %0d", poll_count, c0 + 1); end
  endtask

  task automatic test_edge_during_latch();
    logic [7:0] b;
    b = 8'($urandom);
    buttons = b;
    latch = 1'b1;
    idle(5);
    c_clk = 1'b1;
    idle(6);
    c_clk = 1'b0;
    idle(9);
    latch = 1'b0;
    idle(4);
    total++;
    if (data !== model_bit(b, 0)) begin bad++; $display("FAIL edgelatch data: got %b want %b", data, model_bit(b, 0)); end
    pulse(6, 6);
    buttons = ~b;
    shift_rest(b, 1, 6, 6, "latebtn");
  endtask

  task automatic test_timeout();
    int c0;
    apply_reset();
    run_poll(8'($urandom), 3, 3, "tmo_poll");
    while (cyc < t_latch + FC + 3 + TC - 5) @(negedge clk);
    total++;
    if (host_active !== 1'b1) begin bad++; $display("FAIL tmo early active: got %b want 1", host_active); end
    while (cyc < t_latch + FC + 3 + TC + 2) @(negedge clk);
    total += 2;
    if (host_active !== 1'b0) begin bad++; $display("FAIL tmo active: got %b want 0", host_active); end
    if (data !== 1'b1)        begin bad++; $display("FAIL tmo data: got %b want 1", data); end
    c0 = int'(poll_count);
    for (int k = 0; k < 3; k++) pulse(4, 4);
    total += 2;
    if (data !== 1'b1) begin bad++; $display("FAIL tmo cclk data: got %b want 1", data); end
    if (int'(poll_count) !== c0) begin bad++; $display("FAIL tmo cclk count: got %0d want %0d", poll_count, c0); end
  endtask

  task automatic test_reset_mid_shift();
    run_poll(8'($urandom), 4, 4, "pre_rst");
    buttons = 8'hFF;
    do_latch(12);
    for (int k = 0; k < 3; k++) pulse(4, 4);
    #2;
    reset = 1'b1;
    #1;
    total += 4;
    if (data !== 1'b1)        begin bad++; $display("FAIL rstmid data: got %b want 1", data); end
    if (poll_strobe !== 1'b0) begin bad++; $display("FAIL rstmid strobe: got %b want 0", poll_strobe); end
    if (host_active !== 1'b0) begin bad++; $display("FAIL rstmid active: got %b want 0", host_active); end
    if (poll_count !== 16'd0) begin bad++; $display("FAIL rstmid count: got %0d want 0", poll_count); end
    @(negedge clk);
    reset = 1'b0;
    exp_polls = 0;
    idle(2);
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    idle(2);
    release dut.count_q;
    idle(1);
    run_poll(8'($urandom), 4, 4, "wrap");
    total++;
    if (poll_count !== 16'd0) begin bad++; $display("FAIL wrap count: got %0d want 0", poll_count); end
  endtask

  initial begin
    test_reset();
    test_basic_poll();
    test_random_polls();
    test_glitch();
    test_abort();
    test_edge_during_latch();
    test_timeout();
    test_reset_mid_shift();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
